// File: rtl/hv_ngram_encoder.sv
// rtl/hv_ngram_encoder.sv - HDC n-gram encoder core: item memory, rotate-XOR binding, majority bundling
module hv_ngram_encoder #(
    parameter int W         = 32,
    parameter int DEPTH     = 1024,
    parameter int NGRAM_MAX = 8,
    parameter int MAX_GRAMS = 4095,
    localparam int AW = $clog2(DEPTH),
    localparam int NW = $clog2(NGRAM_MAX + 1),
    localparam int CW = $clog2(MAX_GRAMS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          im_we,
    input  logic [AW-1:0] im_addr,
    input  logic [W-1:0]  im_wdata,
    input  logic [NW-1:0] cfg_n,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [AW-1:0] s_sym,
    input  logic          s_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_hv,
    output logic          busy
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam logic [NW-1:0] N_ONE = NW'(1);
    localparam logic [CW-1:0] C_SAT = '1;

    state_t        r_state, w_next;
    logic [W-1:0]  r_mem [DEPTH];
    logic [W-1:0]  r_rd, r_m, r_bind, r_out_hv;
    logic [NW-1:0] r_n, r_pos, r_pos1, r_pos2;
    logic          r_v1, r_v2, r_v3, r_c1, r_c2, r_l1, r_l2, r_l3, r_l4;
    logic [CW-1:0] r_cnt [W];
    logic [CW-1:0] r_grams;
    logic          w_accept, w_close, w_start;
    logic [2*W-1:0] w_rot;
    logic [W-1:0]  w_maj;

    assign w_accept  = s_valid && (r_state == S_RUN);
    assign w_close   = s_last || (r_pos == r_n - N_ONE);
    assign w_start   = start && (r_state == S_IDLE);
    assign w_rot     = {r_m, r_m} >> r_pos2;
    assign s_ready   = (r_state == S_RUN);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_hv    = r_out_hv;

    // Strict majority: ties and an empty document resolve to 0
    always_comb begin
        w_maj = '0;
        for (int i = 0; i < W; i++)
            w_maj[i] = ({r_cnt[i], 1'b0} > {1'b0, r_grams});
    end

    always_ff @(posedge clk) begin
        if (im_we)
            r_mem[im_addr] <= im_wdata;
        r_rd <= r_mem[s_sym];
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_accept && s_last) w_next = S_FLUSH;
            S_FLUSH: if (r_l4) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n <= N_ONE; r_pos <= '0; r_pos1 <= '0; r_pos2 <= '0;
            r_m <= '0; r_bind <= '0; r_out_hv <= '0; r_grams <= '0;
            {r_v1, r_v2, r_v3, r_c1, r_c2, r_l1, r_l2, r_l3, r_l4} <= '0;
            for (int i = 0; i < W; i++) r_cnt[i] <= '0;
        end else begin
            // Stage 1: symbol accepted, memory read issued
            r_v1   <= w_accept;
            r_c1   <= w_accept && w_close;
            r_l1   <= w_accept && s_last;
            r_pos1 <= r_pos;
            // Stage 2: item vector registered
            r_m    <= r_rd;
            r_v2   <= r_v1;
            r_c2   <= r_c1;
            r_l2   <= r_l1;
            r_pos2 <= r_pos1;
            // Stage 3: bind, marking closed n-grams for bundling
            r_v3   <= r_v2 && r_c2;
            r_l3   <= r_l2;
            r_l4   <= r_l3;
            if (r_v2)
                r_bind <= ((r_pos2 == '0) ? '0 : r_bind) ^ w_rot[W-1:0];
            if (r_l4)
                r_out_hv <= w_maj;

            if (w_start) begin
                r_n     <= (cfg_n == '0) ? N_ONE : cfg_n;
                r_pos   <= '0;
                r_bind  <= '0;
                r_grams <= '0;
                for (int i = 0; i < W; i++) r_cnt[i] <= '0;
            end else begin
                if (w_accept)
                    r_pos <= w_close ? '0 : r_pos + N_ONE;
                if (r_v3) begin
                    if (r_grams != C_SAT) r_grams <= r_grams + CW'(1);
                    for (int i = 0; i < W; i++)
                        if (r_cnt[i] != C_SAT) r_cnt[i] <= r_cnt[i] + CW'(r_bind[i]);
                end
            end
        end
    end
endmodule

// File: tb/tb_hv_ngram_encoder.sv
// tb/tb_hv_ngram_encoder.sv - randomized self-checking bench for hv_ngram_encoder
module tb_hv_ngram_encoder;
    localparam int W = 32, DEPTH = 64, NGRAM_MAX = 8, MAX_GRAMS = 15;
    localparam int AW = 6, NW = 4, SAT = 15;

    logic          clk, rst, im_we, start, s_valid, s_ready, s_last, out_valid, out_ready, busy;
    logic [AW-1:0] im_addr, s_sym;
    logic [W-1:0]  im_wdata, out_hv;
    logic [NW-1:0] cfg_n;

    hv_ngram_encoder #(.W(W), .DEPTH(DEPTH), .NGRAM_MAX(NGRAM_MAX), .MAX_GRAMS(MAX_GRAMS)) dut (
        .clk(clk), .rst(rst), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cfg_n(cfg_n), .start(start), .s_valid(s_valid), .s_ready(s_ready), .s_sym(s_sym),
        .s_last(s_last), .out_valid(out_valid), .out_ready(out_ready), .out_hv(out_hv), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] im [DEPTH];
    int          q[$];
    int          total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int p);
        return (p == 0) ? x : ((x >> p) | (x << (32 - p)));
    endfunction

    // Document split into tumbling chunks of n; trailing partial chunk is its own gram
    function automatic logic [31:0] model(input int cfg);
        int n, grams;
        int cnt[32];
        logic [31:0] b, res;
        n = (cfg == 0) ? 1 : cfg;
        grams = 0;
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        for (int g = 0; g < q.size(); g += n) begin
            b = '0;
            for (int j = 0; j < n && g + j < q.size(); j++) b ^= rotr(im[q[g+j]], j);
            grams = (grams + 1 > SAT) ? SAT : grams + 1;
            for (int i = 0; i < 32; i++) cnt[i] = (cnt[i] + b[i] > SAT) ? SAT : cnt[i] + b[i];
        end
        res = '0;
        for (int i = 0; i < 32; i++) res[i] = (2 * cnt[i] > grams);
        return res;
    endfunction

    task automatic run_doc(input int cfg, input bit bubbles, input int hold, input string tag,
                           output logic [31:0] got);
        int i, lat;
        logic [31:0] exp, held;
        exp = model(cfg);
        cfg_n = NW'(cfg); start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ":busy"}, 32'(busy), 32'd1);
        i = 0;
        while (i < q.size()) begin
            s_valid = !(bubbles && ($urandom_range(0, 1) == 1));
            s_sym   = AW'(q[i]);
            s_last  = (i == q.size() - 1);
            start   = 1'($urandom_range(0, 1));
            cfg_n   = NW'($urandom_range(0, 8));
            chk({tag, ":s_ready"}, 32'(s_ready), 32'd1);
            tick();
            if (s_valid) i++;
        end
        s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, ":latency"}, 32'(lat), 32'd4);
        chk({tag, ":out_hv"}, out_hv, exp);
        got  = out_hv;
        held = out_hv;
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            tick();
            chk({tag, ":hold_hv"}, out_hv, held);
            chk({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ":hold_s_ready"}, 32'(s_ready), 32'd0);
        end
        start = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ":valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, ":idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] got, ref_hv;
        rst = 1'b1; im_we = 1'b0; im_addr = '0; im_wdata = '0; cfg_n = '0; start = 1'b0;
        s_valid = 1'b0; s_sym = '0; s_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst:s_ready", 32'(s_ready), 32'd0);
        chk("rst:out_valid", 32'(out_valid), 32'd0);
        chk("rst:out_hv", out_hv, 32'd0);
        chk("rst:busy", 32'(busy), 32'd0);

        for (int a = 0; a < DEPTH; a++) begin
            im[a] = (a == 0) ? 32'h0000_0001 : (a == 1) ? 32'h8000_0000 :
                    (a == 2) ? 32'hFFFF_0000 : $urandom;
            im_we = 1'b1; im_addr = AW'(a); im_wdata = im[a];
            tick();
        end
        im_we = 1'b0;

        q = '{0, 1};       run_doc(2, 0, 0, "bind", got);  chk("bind:const", got, 32'h4000_0001);
        q = '{0, 0, 1};    run_doc(1, 0, 0, "maj", got);   chk("maj:const", got, 32'h0000_0001);
        q = '{0, 1};       run_doc(1, 0, 0, "tie", got);   chk("tie:const", got, 32'h0);
        q = '{2, 2, 2, 1}; run_doc(3, 0, 5, "partial", got);
        q = '{0, 1, 2, 1, 2};
        run_doc(2, 0, 0, "b2b", ref_hv);
        run_doc(2, 1, 1, "bubble", got);
        chk("bubble:same", got, ref_hv);
        q = '{1};          run_doc(0, 0, 0, "cfg0", got);  chk("cfg0:const", got, 32'h8000_0000);

        cfg_n = NW'(2); start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_valid = 1'b1; s_sym = AW'(k + 3); s_last = 1'b0;
            tick();
        end
        s_valid = 1'b0; rst = 1'b1;
        tick();
        chk("midrst:s_ready", 32'(s_ready), 32'd0);
        chk("midrst:out_valid", 32'(out_valid), 32'd0);
        chk("midrst:out_hv", out_hv, 32'd0);
        chk("midrst:busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        q = '{0, 1};       run_doc(2, 0, 0, "after_rst", got); chk("after_rst:const", got, 32'h4000_0001);

        for (int d = 0; d < 12; d++) begin
            int ns;
            ns = $urandom_range(1, 40);
            q.delete();
            for (int k = 0; k < ns; k++) q.push_back($urandom_range(0, DEPTH - 1));
            run_doc($urandom_range(0, NGRAM_MAX), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $sformatf("rand%0d", d), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
